// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline sequencer for the RV32I core: produces the decoder stall and the update_pc
// redirect pulse from bus wait-states, load-use hazards and taken branches.
module rv32i_pipe_ctrl #(
    parameter int unsigned LD_USE_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT   = 256,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic [4:0]           dec_rd,
    input  logic [4:0]           fetch_rs1,
    input  logic [4:0]           fetch_rs2,
    input  logic                 mem_waitrequest,
    input  logic                 branch_taken,
    output logic                 stall,
    output logic                 update_pc,
    output logic                 bus_err,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int unsigned WW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
    localparam logic [3:0]    LDC = 4'(LD_USE_CYCLES);

    typedef enum logic [1:0] {RUN, MEM_WAIT, LD_USE} state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         wcnt_q, wcnt_d;
    logic [3:0]            bcnt_q, bcnt_d;
    logic                  pend_br_q, pend_br_d;
    logic                  update_pc_q, update_pc_d;
    logic                  bus_err_q, bus_err_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, flush_cnt_q;
    logic                  mem, haz, br, stall_raw;

    assign mem = dec_load | dec_store;
    assign haz = dec_load & (|dec_rd) & ((dec_rd == fetch_rs1) | (dec_rd == fetch_rs2));
    // A branch on the update_pc cycle is dropped: the decoder is already flushing.
    assign br  = branch_taken & ~update_pc_q;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        bcnt_d      = bcnt_q;
        pend_br_d   = pend_br_q;
        update_pc_d = 1'b0;
        bus_err_d   = 1'b0;
        stall_raw   = 1'b0;
        case (state_q)
            RUN: begin
                stall_raw = (mem & mem_waitrequest) | haz;
                if (br) begin
                    update_pc_d = 1'b1;
                end else if (mem & mem_waitrequest) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WW'(1);
                end else if (haz) begin
                    state_d = LD_USE;
                    bcnt_d  = 4'd1;
                end
            end
            MEM_WAIT: begin
                stall_raw = 1'b1;
                pend_br_d = pend_br_q | br;
                if (!mem_waitrequest) begin
                    update_pc_d = pend_br_q | br;
                    pend_br_d   = 1'b0;
                    if (haz) begin
                        state_d = LD_USE;
                        bcnt_d  = 4'd1;
                    end else begin
                        stall_raw = 1'b0;
                        state_d   = RUN;
                    end
                end else if ((MEM_TIMEOUT != 0) && (wcnt_q == TMO)) begin
                    bus_err_d   = 1'b1;
                    update_pc_d = pend_br_q | br;
                    pend_br_d   = 1'b0;
                    state_d     = RUN;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            LD_USE: begin
                stall_raw = (bcnt_q < LDC);
                if (br) begin
                    update_pc_d = 1'b1;
                    state_d     = RUN;
                end else if (bcnt_q == LDC) begin
                    state_d = RUN;
                end else begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign stall = reset_n & stall_raw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            bcnt_q      <= '0;
            pend_br_q   <= 1'b0;
            update_pc_q <= 1'b0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            bcnt_q      <= bcnt_d;
            pend_br_q   <= pend_br_d;
            update_pc_q <= update_pc_d;
            bus_err_q   <= bus_err_d;
            if (stall_raw && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (update_pc_q && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign update_pc = update_pc_q;
    assign bus_err   = bus_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl: u0 (LD_USE=2, TIMEOUT=4, 4-bit counters) and
// u1 (LD_USE=1, no timeout, 32-bit counters) share the same stimulus.
module tb_rv32i_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, dec_load, dec_store, mem_waitrequest, branch_taken;
    logic [4:0] dec_rd, fetch_rs1, fetch_rs2;
    logic       stall0, upd0, err0, stall1, upd1, err1;
    logic [3:0] scnt0, fcnt0;
    logic [31:0] scnt1, fcnt1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rv32i_pipe_ctrl #(.LD_USE_CYCLES(2), .MEM_TIMEOUT(4), .CNT_WIDTH(4)) u0 (
        .clk(clk), .reset_n(reset_n), .dec_load(dec_load), .dec_store(dec_store),
        .dec_rd(dec_rd), .fetch_rs1(fetch_rs1), .fetch_rs2(fetch_rs2),
        .mem_waitrequest(mem_waitrequest), .branch_taken(branch_taken),
        .stall(stall0), .update_pc(upd0), .bus_err(err0),
        .stall_cnt(scnt0), .flush_cnt(fcnt0));

    rv32i_pipe_ctrl #(.LD_USE_CYCLES(1), .MEM_TIMEOUT(0), .CNT_WIDTH(32)) u1 (
        .clk(clk), .reset_n(reset_n), .dec_load(dec_load), .dec_store(dec_store),
        .dec_rd(dec_rd), .fetch_rs1(fetch_rs1), .fetch_rs2(fetch_rs2),
        .mem_waitrequest(mem_waitrequest), .branch_taken(branch_taken),
        .stall(stall1), .update_pc(upd1), .bus_err(err1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dec_load = 0; dec_store = 0; dec_rd = 0; fetch_rs1 = 0; fetch_rs2 = 0;
        mem_waitrequest = 0; branch_taken = 0;
    endtask

    task automatic reset_dut();
        reset_n = 0;
        clear_inputs();
        step();
        step();
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        dec_load = 1; dec_store = 1; dec_rd = 5; fetch_rs1 = 5;
        mem_waitrequest = 1; branch_taken = 1;
        step();
        step();
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall0); end
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL rst_stall1 got=%b exp=0", stall1); end
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL rst_upd got=%b exp=0", upd0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err0); end
        total++; if (scnt0 !== 4'd0) begin bad++; $display("FAIL rst_scnt got=%0d exp=0", scnt0); end
        total++; if (fcnt0 !== 4'd0) begin bad++; $display("FAIL rst_fcnt got=%0d exp=0", fcnt0); end
    endtask

    task automatic test_branch();
        reset_dut();
        branch_taken = 1;
        #1;
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL br_stall got=%b exp=0", stall0); end
        step();
        total++; if (upd0 !== 1'b1) begin bad++; $display("FAIL br_upd got=%b exp=1", upd0); end
        step();
        branch_taken = 0;
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL br_no_back2back got=%b exp=0", upd0); end
        total++; if (fcnt0 !== 4'd1) begin bad++; $display("FAIL br_fcnt got=%0d exp=1", fcnt0); end
        // redirect during a load-use bubble
        dec_load = 1; dec_rd = 5; fetch_rs1 = 5;
        step();
        clear_inputs();
        branch_taken = 1;
        #1;
        total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL br_lduse_stall got=%b exp=1", stall0); end
        step();
        branch_taken = 0;
        #1;
        total++; if (upd0 !== 1'b1) begin bad++; $display("FAIL br_lduse_upd got=%b exp=1", upd0); end
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL br_lduse_abort got=%b exp=0", stall0); end
        step();
        total++; if (fcnt0 !== 4'd2) begin bad++; $display("FAIL br_fcnt2 got=%0d exp=2", fcnt0); end
    endtask

    task automatic test_ld_use();
        reset_dut();
        dec_load = 1; dec_rd = 5; fetch_rs2 = 5;
        #1;
        total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL ld_c0 got=%b exp=1", stall0); end
        total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL ld1_c0 got=%b exp=1", stall1); end
        step();
        clear_inputs();
        #1;
        total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL ld_c1 got=%b exp=1", stall0); end
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL ld1_c1 got=%b exp=0", stall1); end
        step();
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL ld_c2 got=%b exp=0", stall0); end
        step();
        total++; if (scnt0 !== 4'd2) begin bad++; $display("FAIL ld_scnt got=%0d exp=2", scnt0); end
        total++; if (scnt1 !== 32'd1) begin bad++; $display("FAIL ld1_scnt got=%0d exp=1", scnt1); end
        dec_load = 1; dec_rd = 0; fetch_rs1 = 0; fetch_rs2 = 0;
        #1;
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL ld_rd0 got=%b exp=0", stall0); end
        step();
        clear_inputs();
        dec_store = 1; dec_rd = 7; fetch_rs1 = 7;
        #1;
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL ld_store got=%b exp=0", stall0); end
        step();
        clear_inputs();
        dec_load = 1; dec_rd = 7; fetch_rs1 = 7; fetch_rs2 = 3;
        #1;
        total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL ld_rs1 got=%b exp=1", stall0); end
        step();
        clear_inputs();
        step();
        step();
        total++; if (scnt0 !== 4'd4) begin bad++; $display("FAIL ld_scnt2 got=%0d exp=4", scnt0); end
    endtask

    task automatic test_mem_wait();
        reset_dut();
        dec_store = 1; mem_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL mw_stall c%0d got=%b exp=1", i, stall0); end
            step();
            total++; if (err0 !== 1'b0) begin bad++; $display("FAIL mw_err c%0d got=%b exp=0", i, err0); end
        end
        mem_waitrequest = 0;
        #1;
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL mw_release got=%b exp=0", stall0); end
        step();
        dec_store = 0;
        #1;
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL mw_err_end got=%b exp=0", err0); end
        total++; if (scnt0 !== 4'd3) begin bad++; $display("FAIL mw_scnt got=%0d exp=3", scnt0); end
    endtask

    task automatic test_timeout();
        reset_dut();
        dec_store = 1; mem_waitrequest = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL to_stall c%0d got=%b exp=1", i, stall0); end
            total++; if (err0 !== 1'b0) begin bad++; $display("FAIL to_early c%0d got=%b exp=0", i, err0); end
            step();
        end
        dec_store = 0;
        #1;
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err0); end
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL to_release got=%b exp=0", stall0); end
        total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL to_none_stall got=%b exp=1", stall1); end
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL to_none_err got=%b exp=0", err1); end
        step();
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", err0); end
        mem_waitrequest = 0;
        step();
    endtask

    task automatic test_branch_in_wait();
        reset_dut();
        dec_store = 1; mem_waitrequest = 1;
        step();
        branch_taken = 1;
        #1;
        total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL bw_stall got=%b exp=1", stall0); end
        step();
        branch_taken = 0;
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL bw_hold1 got=%b exp=0", upd0); end
        step();
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL bw_hold2 got=%b exp=0", upd0); end
        mem_waitrequest = 0;
        #1;
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL bw_release got=%b exp=0", stall0); end
        step();
        dec_store = 0;
        total++; if (upd0 !== 1'b1) begin bad++; $display("FAIL bw_upd got=%b exp=1", upd0); end
        step();
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL bw_single got=%b exp=0", upd0); end
        total++; if (fcnt0 !== 4'd1) begin bad++; $display("FAIL bw_fcnt got=%0d exp=1", fcnt0); end
        // reset abandons a wait with a pending branch
        dec_store = 1; mem_waitrequest = 1;
        step();
        branch_taken = 1;
        step();
        branch_taken = 0;
        reset_n = 0;
        #1;
        total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL bw_rst_stall got=%b exp=0", stall0); end
        step();
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL bw_rst_upd got=%b exp=0", upd0); end
        total++; if (scnt0 !== 4'd0) begin bad++; $display("FAIL bw_rst_scnt got=%0d exp=0", scnt0); end
        reset_n = 1;
        clear_inputs();
        step();
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL bw_rst_pend1 got=%b exp=0", upd0); end
        step();
        total++; if (upd0 !== 1'b0) begin bad++; $display("FAIL bw_rst_pend2 got=%b exp=0", upd0); end
    endtask

    task automatic test_saturate();
        reset_dut();
        dec_store = 1; mem_waitrequest = 1;
        for (int i = 0; i < 15; i++) step();
        total++; if (scnt0 !== 4'hF) begin bad++; $display("FAIL sat_15 got=%0d exp=15", scnt0); end
        for (int i = 0; i < 5; i++) step();
        total++; if (scnt0 !== 4'hF) begin bad++; $display("FAIL sat_hold got=%0d exp=15", scnt0); end
        total++; if (scnt1 !== 32'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", scnt1); end
        clear_inputs();
        step();
    endtask

    initial begin
        reset_n = 0;
        clear_inputs();
        test_reset();
        test_branch();
        test_ld_use();
        test_mem_wait();
        test_timeout();
        test_branch_in_wait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
